// File: rtl/axis_mash11_modulator_pkg.sv
// Shared types and constants for the MASH 1-1 DAC modulator.
// Holds the default width, DAC code values and sample conversion.
package mash_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  // dac_code = y + 1
  localparam logic [1:0] CODE_M1 = 2'd0;
  localparam logic [1:0] CODE_0  = 2'd1;
  localparam logic [1:0] CODE_P1 = 2'd2;
  localparam logic [1:0] CODE_P2 = 2'd3;

  // Two's complement to offset binary: flip the MSB.
  function automatic logic [DEF_DATA_WIDTH-1:0] to_offset_binary(
    input logic signed [DEF_DATA_WIDTH-1:0] s
  );
    return {~s[DEF_DATA_WIDTH-1], s[DEF_DATA_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/axis_mash11_modulator_if.sv
// AXI-Stream sample link from the NCO into the modulator.
// master drives tdata/tvalid, slave returns tready.
interface axis_mash11_modulator_if
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_mash11_modulator_stage.sv
// First-order error-feedback accumulator with carry out.
// Ports: aclk, arst (sync, high), en, din; acc_next, carry (comb).
module mash_stage #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         arst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc_next,
  output logic         carry
);

  logic [W-1:0] acc_q;
  logic [W:0]   sum;

  assign sum      = {1'b0, acc_q} + {1'b0, din};
  assign carry    = sum[W];
  assign acc_next = sum[W-1:0];

  always_ff @(posedge aclk) begin
    if (arst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/axis_mash11_modulator.sv
// MASH 1-1 modulator: zero-order-held AXIS sample -> 2-bit DAC code.
// Ports: aclk, arst (sync, high), enable, s_axis_data (slave),
//        dac_code, dac_valid, underrun.
module axis_mash11_modulator
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OSR_LOG2   = 6
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  enable,
  axis_mash11_modulator_if.slave s_axis_data,
  output logic [1:0]            dac_code,
  output logic                  dac_valid,
  output logic                  underrun
);

  logic [OSR_LOG2-1:0]   cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] acc1_next;
  logic [DATA_WIDTH-1:0] acc2_next;
  logic                  c1;
  logic                  c2;
  logic                  c2_d;
  logic [1:0]            code;
  logic                  accept;

  assign s_axis_data.tready = enable & ~arst & (cnt == '0);
  assign accept = s_axis_data.tready & s_axis_data.tvalid;

  // y + 1 = c1 + c2 + (1 - c2_d); range 0..3
  assign code = {1'b0, c1} + {1'b0, c2} + {1'b0, ~c2_d};

  mash_stage #(.W(DATA_WIDTH)) u_stage1 (
    .aclk     (aclk),
    .arst     (arst),
    .en       (enable),
    .din      (hold),
    .acc_next (acc1_next),
    .carry    (c1)
  );

  // Stage 2 integrates stage 1's fresh residue in the same cycle.
  mash_stage #(.W(DATA_WIDTH)) u_stage2 (
    .aclk     (aclk),
    .arst     (arst),
    .en       (enable),
    .din      (acc1_next),
    .acc_next (acc2_next),
    .carry    (c2)
  );

  always_ff @(posedge aclk) begin
    if (arst) begin
      cnt       <= '0;
      hold      <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
      c2_d      <= 1'b0;
      dac_code  <= CODE_0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      dac_valid <= enable;
      underrun  <= s_axis_data.tready & ~s_axis_data.tvalid;
      if (enable) begin
        cnt      <= cnt + OSR_LOG2'(1);
        c2_d     <= c2;
        dac_code <= code;
      end
      if (accept) begin
        hold <= to_offset_binary(s_axis_data.tdata);
      end
    end
  end

endmodule

// File: tb/tb_axis_mash11_modulator.sv
// Directed bench for axis_mash11_modulator (OSR_LOG2 = 2).
// Vector table, then model-checked corner sequences.
module tb_axis_mash11_modulator;

  logic       aclk = 1'b0;
  logic       arst;
  logic       enable;
  logic [1:0] dac_code;
  logic       dac_valid;
  logic       underrun;

  axis_mash11_modulator_if #(.DATA_WIDTH(16)) s_axis_data ();

  axis_mash11_modulator #(
    .DATA_WIDTH (16),
    .OSR_LOG2   (2)
  ) dut (
    .aclk        (aclk),
    .arst        (arst),
    .enable      (enable),
    .s_axis_data (s_axis_data),
    .dac_code    (dac_code),
    .dac_valid   (dac_valid),
    .underrun    (underrun)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (integer arithmetic)
  int m_cnt, m_acc1, m_acc2, m_c2d, m_hold;
  int m_code, m_valid, m_und;

  // last observed / predicted values
  int obs_rdy, obs_code, obs_valid, obs_und, exp_rdy;

  typedef struct {
    bit          rst;
    bit          en;
    bit          tv;
    logic [15:0] td;
    bit          rdy;
    int          code;
    bit          valid;
    bit          und;
  } vec_t;

  vec_t tab[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_ready(input bit rst, input bit en);
    return (en && !rst && m_cnt == 0) ? 1 : 0;
  endfunction

  function automatic void model_step(
    input bit rst, input bit en, input bit tv,
    input logic [15:0] td, input int rdy
  );
    int s1, s2, c1, c2, sv;
    if (rst) begin
      m_cnt = 0; m_acc1 = 0; m_acc2 = 0; m_c2d = 0;
      m_hold = 32768; m_code = 1; m_valid = 0; m_und = 0;
    end else begin
      m_und = (rdy != 0 && !tv) ? 1 : 0;
      m_valid = en ? 1 : 0;
      if (en) begin
        s1 = m_acc1 + m_hold;
        c1 = s1 / 65536;
        m_acc1 = s1 % 65536;
        s2 = m_acc2 + m_acc1;
        c2 = s2 / 65536;
        m_acc2 = s2 % 65536;
        m_code = c1 + c2 - m_c2d + 1;
        m_c2d = c2;
        m_cnt = (m_cnt + 1) % 4;
      end
      if (rdy != 0 && tv) begin
        sv = $signed(td);
        m_hold = sv + 32768;
      end
    end
  endfunction

  task automatic step(
    input bit rst, input bit en, input bit tv, input logic [15:0] td
  );
    @(negedge aclk);
    arst = rst;
    enable = en;
    s_axis_data.tvalid = tv;
    s_axis_data.tdata = td;
    #1;
    obs_rdy = int'(s_axis_data.tready);
    exp_rdy = model_ready(rst, en);
    @(posedge aclk);
    #1;
    obs_code = int'(dac_code);
    obs_valid = int'(dac_valid);
    obs_und = int'(underrun);
    model_step(rst, en, tv, td, exp_rdy);
  endtask

  task automatic mstep(
    input string tag, input bit rst, input bit en,
    input bit tv, input logic [15:0] td
  );
    step(rst, en, tv, td);
    check({tag, ".tready"}, obs_rdy, exp_rdy);
    check({tag, ".code"}, obs_code, m_code);
    check({tag, ".valid"}, obs_valid, m_valid);
    check({tag, ".underrun"}, obs_und, m_und);
  endtask

  initial begin
    int rdy0[8], cd0[8], rdy1[6], cd1[6];
    int k, ysum, n3, back3, und_cnt, frz, bad_rng;

    arst = 1'b1;
    enable = 1'b0;
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tdata = '0;
    m_cnt = 0; m_acc1 = 0; m_acc2 = 0; m_c2d = 0; m_hold = 32768;

    // reset: 3 cycles with enable and tvalid high
    for (int i = 0; i < 3; i++)
      tab[i] = '{1, 1, 1, 16'h0000, 0, 1, 0, 0};
    // hold 0x8000 -> 1,2,2,1 repeating, one slot in four
    rdy0 = '{1, 0, 0, 0, 1, 0, 0, 0};
    cd0  = '{1, 2, 2, 1, 1, 2, 2, 1};
    for (int i = 0; i < 8; i++)
      tab[3+i] = '{0, 1, 1, 16'h0000, rdy0[i], cd0[i], 1, 0};
    // 0x4000 accepted; old hold used on the accept edge
    rdy1 = '{1, 0, 0, 0, 1, 0};
    cd1  = '{1, 2, 2, 2, 2, 1};
    for (int i = 0; i < 6; i++)
      tab[11+i] = '{0, 1, 1, 16'h4000, rdy1[i], cd1[i], 1, 0};

    for (int i = 0; i < 17; i++) begin
      step(tab[i].rst, tab[i].en, tab[i].tv, tab[i].td);
      check($sformatf("vec%0d.tready", i), obs_rdy, int'(tab[i].rdy));
      check($sformatf("vec%0d.code", i), obs_code, tab[i].code);
      check($sformatf("vec%0d.valid", i), obs_valid, int'(tab[i].valid));
      check($sformatf("vec%0d.underrun", i), obs_und, int'(tab[i].und));
    end

    // tvalid low across one slot; junk tdata must be ignored
    und_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mstep("undr", 0, 1, 0, 16'h1234);
      und_cnt += obs_und;
    end
    for (int i = 0; i < 6; i++) begin
      mstep("undr_post", 0, 1, 1, 16'h4000);
      und_cnt += obs_und;
    end
    check("underrun_pulses", und_cnt, 1);

    // freeze for 10 cycles mid-stream
    mstep("pre_frz", 0, 1, 1, 16'hC000);
    k = obs_code;
    frz = 0;
    for (int i = 0; i < 10; i++) begin
      mstep("frz", 0, 0, 1, 16'h2000);
      if (obs_code != k || obs_valid != 0 || obs_rdy != 0) frz++;
    end
    check("freeze_held", frz, 0);
    for (int i = 0; i < 12; i++)
      mstep("resume", 0, 1, 1, 16'hC000);

    // reset mid-stream
    step(1, 1, 1, 16'h7000);
    check("midrst.tready", obs_rdy, 0);
    check("midrst.code", obs_code, 1);
    check("midrst.valid", obs_valid, 0);
    check("midrst.underrun", obs_und, 0);
    for (int i = 0; i < 8; i++)
      mstep("post_rst", 0, 1, 1, 16'h0000);

    // most negative sample: mean y = 0
    mstep("rstA", 1, 1, 1, 16'h8000);
    ysum = 0;
    for (int i = 0; i < 4096; i++) begin
      mstep("negfs", 0, 1, 1, 16'h8000);
      ysum += obs_code - 1;
    end
    check("negfs_sum_lo", (ysum >= -1) ? 1 : 0, 1);
    check("negfs_sum_hi", (ysum <= 1) ? 1 : 0, 1);

    // most positive sample: mean y just under 1
    mstep("rstB", 1, 1, 1, 16'h7FFF);
    ysum = 0; n3 = 0; back3 = 0; bad_rng = 0; k = 0;
    for (int i = 0; i < 8192; i++) begin
      mstep("posfs", 0, 1, 1, 16'h7FFF);
      ysum += obs_code - 1;
      if (obs_code == 3) n3++;
      if (obs_code == 3 && k == 3) back3++;
      if (obs_code < 0 || obs_code > 3) bad_rng++;
      k = obs_code;
    end
    check("posfs_sum_lo", (ysum >= 8190) ? 1 : 0, 1);
    check("posfs_sum_hi", (ysum <= 8193) ? 1 : 0, 1);
    check("posfs_code3_seen", (n3 > 0) ? 1 : 0, 1);
    check("posfs_code3_twice", back3, 0);
    check("posfs_range", bad_rng, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
